// File: rtl/rns_pkg.sv
// Shared constants and width helpers for the residue datapath.
// Used by the three-operand modular adder front end, the downstream
// carry-select MUX stage and the sibling modular multiplier.
package rns_pkg;

  // Default channel modulus (largest prime below 2^12).
  localparam int unsigned MOD_DEFAULT = 4093;

  // Width that holds the sum of three residues of width n without overflow.
  function automatic int unsigned sum_w(input int unsigned n);
    return n + 2;
  endfunction

  // 2*MOD, the second reduction constant.
  function automatic int unsigned two_mod(input int unsigned m);
    return 2 * m;
  endfunction

endpackage

// File: rtl/rns_pipe_stage.sv
// Single valid/ready register slice with a parameterised payload width.
// The enclosing pipeline computes the stage enable; this slice only holds
// the valid bit and the payload.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage advances this cycle
//   in_valid   : upstream valid
//   in_data    : upstream payload
//   valid_q    : registered valid
//   data_q     : registered payload (holds while en is low)
module rns_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         valid_d;
  logic [W-1:0] data_d;

  // Next state: load on enable; payload only captured for real beats.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rns_mod3_add_pre.sv
// Two-stage pipelined front end of the three-operand modular adder.
// Stage 1 registers s = a+b+c; stage 2 registers the candidates s, s-MOD,
// s-2*MOD (low N bits) with the flags carry2 = s>=MOD, carry3 = s>=2*MOD,
// from which the downstream MUX stage selects (a+b+c) mod MOD.
// Optional macro RNS_RANGE_CHECK_EN adds a sticky operand range error.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   a, b, c             : residue operands (< MOD)
//   out_valid, out_ready: output handshake
//   out1, out2, out3    : candidates s, s-MOD, s-2*MOD (low N bits)
//   carry2, carry3      : s >= MOD, s >= 2*MOD
//   out_last            : last beat of an LEN-beat frame
//   err, err_clr        : sticky range error and its clear (macro only)
module rns_mod3_add_pre
  import rns_pkg::*;
#(
  parameter int unsigned N   = 12,
  parameter int unsigned MOD = MOD_DEFAULT,
  parameter int unsigned LEN = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3,
  output logic         carry2,
  output logic         carry3,
  output logic         out_last
`ifdef RNS_RANGE_CHECK_EN
  ,
  output logic         err,
  input  logic         err_clr
`endif
);

  localparam int unsigned SUM_W   = sum_w(N);
  localparam int unsigned D_W     = SUM_W + 1;
  localparam int unsigned TWO_MOD = two_mod(MOD);
  localparam int unsigned CAND_W  = 3 * N + 2;
  localparam int unsigned CNT_W   = (LEN > 1) ? $clog2(LEN) : 1;

  logic                    en1;
  logic                    en2;
  logic                    v1_q;
  logic                    v2_q;
  logic [SUM_W-1:0]        s_d;
  logic [SUM_W-1:0]        s_q;
  logic signed [D_W-1:0]   d1_c;
  logic signed [D_W-1:0]   d2_c;
  logic                    carry2_c;
  logic                    carry3_c;
  logic [CAND_W-1:0]       cand_d;
  logic [CAND_W-1:0]       cand_q;
  logic                    v2_nxt;
  logic                    hs;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last_d;
  logic                    last_q;

  // Pipeline enables: a stage may load when empty or when its successor moves.
  always_comb begin
    en2 = !v2_q || out_ready;
    en1 = !v1_q || en2;
  end

  // Ready is held low while reset is asserted.
  assign in_ready = rst_n & en1;

  // Stage 1 payload: full-width three-operand sum.
  always_comb begin
    s_d = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
  end

  rns_pipe_stage #(.W(SUM_W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en1),
    .in_valid (in_valid),
    .in_data  (s_d),
    .valid_q  (v1_q),
    .data_q   (s_q)
  );

  // Stage 2 payload: signed differences keep the borrow visible; only the
  // low N bits travel on, the flags carry the range information.
  always_comb begin
    d1_c     = $signed({1'b0, s_q}) - $signed(D_W'(MOD));
    d2_c     = $signed({1'b0, s_q}) - $signed(D_W'(TWO_MOD));
    carry2_c = (s_q >= SUM_W'(MOD));
    carry3_c = (s_q >= SUM_W'(TWO_MOD));
    cand_d   = {carry3_c, carry2_c, N'(d2_c), N'(d1_c), N'(s_q)};
  end

  rns_pipe_stage #(.W(CAND_W)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en2),
    .in_valid (v1_q),
    .in_data  (cand_d),
    .valid_q  (v2_q),
    .data_q   (cand_q)
  );

  assign {carry3, carry2, out3, out2, out1} = cand_q;
  assign out_valid = v2_q;

  // Frame counter over output handshakes; out_last is registered from the
  // next-cycle view of stage-2 valid and the counter so it tracks both.
  always_comb begin
    hs     = v2_q && out_ready;
    v2_nxt = en2 ? v1_q : v2_q;
    cnt_d  = cnt_q;
    if (hs) begin
      if (cnt_q == CNT_W'(LEN - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    last_d = v2_nxt && (cnt_d == CNT_W'(LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign out_last = last_q;

`ifdef RNS_RANGE_CHECK_EN
  logic viol_c;
  logic err_d;
  logic err_q;

  // Sticky range error; a new violation wins over a simultaneous clear.
  always_comb begin
    viol_c = in_valid && in_ready &&
             ((a >= N'(MOD)) || (b >= N'(MOD)) || (c >= N'(MOD)));
    err_d  = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (viol_c) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_rns_mod3_add_pre.sv
// Self-checking bench for rns_mod3_add_pre (N=12, MOD=4093, LEN=4).
// A queue of accepted operand triples is the reference; outputs are
// compared on every falling edge.
module tb_rns_mod3_add_pre;

  localparam int N    = 12;
  localparam int MOD  = 4093;
  localparam int LEN  = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] c = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out1;
  logic [N-1:0] out2;
  logic [N-1:0] out3;
  logic         carry2;
  logic         carry3;
  logic         out_last;
`ifdef RNS_RANGE_CHECK_EN
  logic         err;
  logic         err_clr = 1'b0;
`endif

  rns_mod3_add_pre #(.N(N), .MOD(MOD), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .carry2    (carry2),
    .carry3    (carry3),
    .out_last  (out_last)
`ifdef RNS_RANGE_CHECK_EN
    ,
    .err       (err),
    .err_clr   (err_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int a;
    int b;
    int c;
    int acc;
  } beat_t;

  beat_t q[$];
  int    cyc    = 0;
  int    hs_cnt = 0;
  bit    err_m  = 1'b0;

  always @(posedge clk) cyc++;

  // Compare process: everything the outputs must be, from the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hs_cnt = 0;
      err_m  = 1'b0;
    end else begin
      bit    ov_exp;
      beat_t bt;
      int    s;
      int    sel;
      ov_exp = (q.size() > 0) && (cyc >= q[0].acc + 1);
      check("out_valid", out_valid, ov_exp);
      check("in_ready", in_ready, !((q.size() >= 2) && !out_ready));
      check("out_last", out_last, ov_exp && ((hs_cnt % LEN) == LEN - 1));
      if (out_valid && q.size() > 0) begin
        bt = q[0];
        s  = bt.a + bt.b + bt.c;
        check("out1", out1, s & MASK);
        check("out2", out2, (s - MOD) & MASK);
        check("out3", out3, (s - 2 * MOD) & MASK);
        check("carry2", carry2, s >= MOD);
        check("carry3", carry3, s >= 2 * MOD);
        if (bt.a < MOD && bt.b < MOD && bt.c < MOD) begin
          sel = carry3 ? int'(out3) : (carry2 ? int'(out2) : int'(out1));
          check("residue", sel, s % MOD);
        end
        if (out_ready) begin
          void'(q.pop_front());
          hs_cnt++;
        end
      end
`ifdef RNS_RANGE_CHECK_EN
      check("err", err, err_m);
      if (err_clr) err_m = 1'b0;
      if (in_valid && in_ready && (a >= MOD || b >= MOD || c >= MOD)) err_m = 1'b1;
`endif
      if (in_valid && in_ready) begin
        bt.a = int'(a); bt.b = int'(b); bt.c = int'(c); bt.acc = cyc + 1;
        q.push_back(bt);
      end
    end
  end

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 0;
    if (r == 1) return MOD - 1;
`ifdef RNS_RANGE_CHECK_EN
    if (r == 2) return MOD + int'($urandom_range(0, MASK - MOD));
`endif
    return int'($urandom_range(0, MOD - 1));
  endfunction

  // Single beat into an empty pipe with hand-computed expectations.
  task automatic directed(input string nm, input int ta, input int tb_, input int tc,
                          input int e1, input int e2, input int e3, input int ec2, input int ec3);
    bit found;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    a = N'(ta); b = N'(tb_); c = N'(tc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        check({nm, "_latency"}, i, 1);
        check({nm, "_out1"}, out1, e1);
        check({nm, "_out2"}, out2, e2);
        check({nm, "_out3"}, out3, e3);
        check({nm, "_carry2"}, carry2, ec2);
        check({nm, "_carry3"}, carry3, ec3);
      end
    end
    if (!found) check({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, outs, cycles;
    bit          took, stall_seen;
    logic [7:0]  last_mask;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_out3", out3, 0);
    check("rst_carry2", carry2, 0);
    check("rst_carry3", carry3, 0);
`ifdef RNS_RANGE_CHECK_EN
    check("rst_err", err, 0);
`endif
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Frame: 8 back-to-back beats, out_last on output beats 4 and 8 only
    out_ready = 1'b1;
    k = 0; outs = 0; cycles = 0; last_mask = '0;
    while (outs < 8 && cycles < 40) begin
      @(posedge clk); #1;
      if (k < 8) begin
        in_valid = 1'b1; a = N'(k + 1); b = N'(2 * k); c = N'(5);
        k++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (out_last) last_mask[outs] = 1'b1;
        outs++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    check("frame_beats", outs, 8);
    check("frame_last_mask", last_mask, 8'b1000_1000);

    // Directed arithmetic points
    directed("sum6",   1,    2,    3,    6,    9,    12,   0, 0);
    directed("summod", 4092, 1,    0,    4093, 0,    3,    1, 0);
    directed("summax", 4092, 4092, 4092, 4084, 4087, 4090, 1, 1);
    directed("zero",   0,    0,    0,    0,    3,    6,    0, 0);
    directed("sum2m",  4092, 4092, 2,    4090, 4093, 0,    1, 1);
    directed("sub2m",  4092, 4092, 1,    4089, 4092, 4095, 1, 0);

    // Stall: out_ready low for loop cycles 3..5
    k = 0; outs = 0; took = 1'b0; stall_seen = 1'b0;
    for (int cy = 0; cy < 30 && outs < 8; cy++) begin
      @(posedge clk); #1;
      if (took) k++;
      in_valid  = (k < 8);
      a = N'(10 * (k + 1)); b = '0; c = '0;
      out_ready = !(cy >= 3 && cy <= 5);
      @(negedge clk);
      took = in_valid && in_ready;
      if (!in_ready) stall_seen = 1'b1;
      if (out_valid && out_ready) begin
        check("stall_order", out1, 10 * (outs + 1));
        outs++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_ready_dropped", stall_seen, 1);
    check("stall_beats", outs, 8);

    // Randomized traffic with a mid-stream reset
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (i == 400) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_last", out_last, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end else begin
        in_valid  = ($urandom_range(0, 9) < 7);
        a = N'(pick()); b = N'(pick()); c = N'(pick());
        out_ready = ($urandom_range(0, 9) < 6);
`ifdef RNS_RANGE_CHECK_EN
        err_clr   = ($urandom_range(0, 9) == 0);
`endif
      end
    end

    // Drain
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
`ifdef RNS_RANGE_CHECK_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);

`ifdef RNS_RANGE_CHECK_EN
    // Range error: set, hold, clear, and violation winning over clear
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    in_valid = 1'b1; a = N'(4093); b = '0; c = '0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0;
    @(negedge clk);
    check("err_set", err, 1);
    repeat (3) @(negedge clk);
    check("err_held", err, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", err, 0);
    @(posedge clk); #1;
    err_clr = 1'b1; in_valid = 1'b1; c = N'(4095);
    @(posedge clk); #1;
    err_clr = 1'b0; in_valid = 1'b0; c = '0;
    @(negedge clk);
    check("err_viol_wins", err, 1);
    repeat (4) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
